// File: rtl/rvga_types.sv
// rvga_types: shared memory-model types (preload modes, response record)
package rvga_types;
  localparam int rvga_mem_word_width_lp = 32;
  typedef logic [rvga_mem_word_width_lp-1:0] rvga_mem_word_t;
  typedef enum logic [1:0] {e_init_zero, e_init_identity, e_init_file} rvga_mem_init_e;
  typedef struct packed {
    logic v;
    logic err;
    rvga_mem_word_t data;
  } rvga_mem_resp_s;
endpackage

// File: rtl/rvga_mem_resp_pipe.sv
// rvga_mem_resp_pipe: latency_p-deep response shift register; last stage keeps err/data while idle, flushed by rst_i
module rvga_mem_resp_pipe
  import rvga_types::*;
#(
  parameter int latency_p = 2,
  parameter int data_width_p = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  rvga_mem_resp_s resp_i,
  output rvga_mem_resp_s resp_o
);
  rvga_mem_resp_s stage [latency_p];
  rvga_mem_resp_s head, tail_in;
  assign head = '{v: resp_i.v, err: resp_i.err, data: rvga_mem_word_t'(resp_i.data[data_width_p-1:0])};
  if (latency_p == 1) begin : g_one
    assign tail_in = head;
  end else begin : g_many
    assign tail_in = stage[latency_p-2];
  end
  always_ff @(posedge clk_i)
    if (rst_i) stage <= '{default: '0};
    else begin
      for (int i = latency_p - 2; i > 0; i--) stage[i] <= stage[i-1];
      if (latency_p > 1) stage[0] <= head;
      stage[latency_p-1] <= tail_in.v ? tail_in
                          : rvga_mem_resp_s'{v: 1'b0, err: stage[latency_p-1].err, data: stage[latency_p-1].data};
    end
  assign resp_o = stage[latency_p-1];
endmodule

// File: rtl/rvga_mem_model.sv
// rvga_mem_model: num_ch_p request channels (r/w valid, byte enables, byte address, data) over one word array, fixed-latency responses (valid, err, data), cycle_o/timeout_o run control
module rvga_mem_model
  import rvga_types::*;
#(
  parameter int    num_ch_p     = 2,
  parameter int    data_width_p = 32,
  parameter int    addr_width_p = 32,
  parameter int    depth_p      = 4096,
  parameter int    latency_p    = 2,
  parameter int    init_mode_p  = 0,
  parameter string init_file_p  = "prog.hex",
  parameter int    timeout_p    = 100000
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [num_ch_p-1:0]                  r_v_i,
  input  logic [num_ch_p-1:0]                  w_v_i,
  input  logic [num_ch_p*(data_width_p/8)-1:0] be_i,
  input  logic [num_ch_p*addr_width_p-1:0]     addr_i,
  input  logic [num_ch_p*data_width_p-1:0]     data_i,
  output logic [num_ch_p-1:0]                  ready_o,
  output logic [num_ch_p*data_width_p-1:0]     data_o,
  output logic [num_ch_p-1:0]                  resp_v_o,
  output logic [num_ch_p-1:0]                  err_o,
  output logic [31:0]                          cycle_o,
  output logic                                 timeout_o
);
  localparam int bw_lp = data_width_p / 8;
  localparam int iw_lp = $clog2(depth_p);
  logic [data_width_p-1:0] mem [depth_p];
  logic [num_ch_p-1:0] acc, err;
  logic [iw_lp-1:0] idx [num_ch_p];
  initial begin
    for (int i = 0; i < depth_p; i++) mem[i] = init_mode_p == int'(e_init_identity) ? data_width_p'(i * 4) : '0;
  end
  assign ready_o = {num_ch_p{~rst_i}};
  for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
    logic [addr_width_p-1:0] addr;
    rvga_mem_resp_s req, resp;
    assign addr = addr_i[c*addr_width_p +: addr_width_p];
    assign idx[c] = addr[iw_lp+1:2];
    assign err[c] = |addr[1:0] || |addr[addr_width_p-1:iw_lp+2];
    assign acc[c] = (r_v_i[c] | w_v_i[c]) & ready_o[c];
    // read data is taken from the array before this edge's writes land
    assign req = '{v: acc[c], err: err[c], data: (err[c] || !r_v_i[c]) ? '0 : rvga_mem_word_t'(mem[idx[c]])};
    rvga_mem_resp_pipe #(.latency_p(latency_p), .data_width_p(data_width_p)) u_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .resp_i(req),
      .resp_o(resp)
    );
    assign resp_v_o[c] = resp.v;
    assign err_o[c] = resp.err;
    assign data_o[c*data_width_p +: data_width_p] = resp.data[data_width_p-1:0];
  end
  // later channels overwrite earlier ones byte by byte, so the highest index wins
  always_ff @(posedge clk_i)
    for (int i = 0; i < num_ch_p; i++)
      for (int j = 0; j < bw_lp; j++)
        if (acc[i] && w_v_i[i] && !err[i] && be_i[i*bw_lp+j]) mem[idx[i]][j*8 +: 8] <= data_i[i*data_width_p+j*8 +: 8];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cycle_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      cycle_o <= cycle_o + 32'(cycle_o != '1);
      timeout_o <= timeout_o || (timeout_p != 0 && cycle_o == 32'(timeout_p - 1));
    end
endmodule

// File: tb/tb_rvga_mem_model.sv
// tb_rvga_mem_model: scoreboard bench for rvga_mem_model with identity preload and latency 2
module tb_rvga_mem_model;
  typedef struct packed {
    logic err;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] r_v_i = '0, w_v_i = '0;
  logic [7:0] be_i = '0;
  logic [63:0] addr_i = '0, data_i = '0;
  logic [1:0] ready_o, resp_v_o, err_o;
  logic [63:0] data_o;
  logic [31:0] cycle_o;
  logic timeout_o;
  logic [1:0] nt_ready, nt_resp_v, nt_err;
  logic [63:0] nt_data;
  logic [31:0] nt_cycle;
  logic nt_timeout;
  int pass_cnt = 0, total_cnt = 0;
  int resp_cnt [2] = '{0, 0};
  exp_t q0 [$], q1 [$];
  logic [31:0] model [4096];

  always #5 clk = ~clk;

  rvga_mem_model #(.init_mode_p(1), .latency_p(2), .timeout_p(20)) dut (
    .clk_i(clk), .rst_i(rst_i), .r_v_i(r_v_i), .w_v_i(w_v_i), .be_i(be_i), .addr_i(addr_i), .data_i(data_i),
    .ready_o(ready_o), .data_o(data_o), .resp_v_o(resp_v_o), .err_o(err_o), .cycle_o(cycle_o), .timeout_o(timeout_o)
  );
  rvga_mem_model #(.init_mode_p(1), .latency_p(2), .timeout_p(0)) dut_nt (
    .clk_i(clk), .rst_i(rst_i), .r_v_i(r_v_i), .w_v_i(w_v_i), .be_i(be_i), .addr_i(addr_i), .data_i(data_i),
    .ready_o(nt_ready), .data_o(nt_data), .resp_v_o(nt_resp_v), .err_o(nt_err), .cycle_o(nt_cycle), .timeout_o(nt_timeout)
  );

  always @(negedge clk) begin : mon
    exp_t got, want;
    for (int c = 0; c < 2; c++)
      if (resp_v_o[c] === 1'b1) begin
        resp_cnt[c]++;
        total_cnt++;
        got = {err_o[c], data_o[c*32 +: 32]};
        if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0))
          $display("FAIL resp_unexpected ch%0d: got err=%b data=%h, required no response", c, got.err, got.data);
        else begin
          if (c == 0) want = q0.pop_front();
          else want = q1.pop_front();
          if (got !== want)
            $display("FAIL resp_ch%0d: got err=%b data=%h, required err=%b data=%h", c, got.err, got.data, want.err, want.data);
          else pass_cnt++;
        end
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    r_v_i = '0;
    w_v_i = '0;
    be_i = '0;
    addr_i = '0;
    data_i = '0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [7:0] be,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic er [2];
    exp_t e;
    a[0] = a0;
    a[1] = a1;
    d[0] = d0;
    d[1] = d1;
    for (int c = 0; c < 2; c++) begin
      er[c] = (a[c][1:0] != 2'b00) || (a[c][31:2] >= 30'd4096);
      if (r[c] || w[c]) begin
        e.err = er[c];
        e.data = (er[c] || !r[c]) ? 32'h0 : model[a[c][13:2]];
        if (c == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    for (int c = 0; c < 2; c++)
      if (w[c] && !er[c])
        for (int b = 0; b < 4; b++)
          if (be[c*4+b]) model[a[c][13:2]][b*8 +: 8] = d[c][b*8 +: 8];
    r_v_i = r;
    w_v_i = w;
    be_i = be;
    addr_i = {a1, a0};
    data_i = {d1, d0};
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle(3);
    total_cnt += 7;
    if (ready_o !== 2'b00) $display("FAIL reset_ready: got %b, required 00", ready_o); else pass_cnt++;
    if (resp_v_o !== 2'b00) $display("FAIL reset_resp_v: got %b, required 00", resp_v_o); else pass_cnt++;
    if (err_o !== 2'b00) $display("FAIL reset_err: got %b, required 00", err_o); else pass_cnt++;
    if (data_o !== 64'h0) $display("FAIL reset_data: got %h, required 0", data_o); else pass_cnt++;
    if (cycle_o !== 32'h0) $display("FAIL reset_cycle: got %0d, required 0", cycle_o); else pass_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b, required 0", timeout_o); else pass_cnt++;
    if (nt_timeout !== 1'b0) $display("FAIL reset_nt_timeout: got %b, required 0", nt_timeout); else pass_cnt++;
    rst_i = 1'b0;
    idle(1);
  endtask

  task automatic test_read_latency();
    logic [31:0] c0;
    c0 = cycle_o;
    total_cnt += 6;
    if (ready_o !== 2'b11) $display("FAIL ready_after_reset: got %b, required 11", ready_o); else pass_cnt++;
    drive(2'b01, 2'b00, 8'h00, 32'h10, 32'h0, 32'h0, 32'h0);
    if (resp_v_o[0] !== 1'b0) $display("FAIL latency_early: got resp_v %b one cycle after request, required 0", resp_v_o[0]); else pass_cnt++;
    idle(1);
    if (resp_v_o[0] !== 1'b1) $display("FAIL latency_resp_v: got %b two cycles after request, required 1", resp_v_o[0]); else pass_cnt++;
    if (cycle_o !== c0 + 32'd2) $display("FAIL latency_cycle: got %0d, required %0d", cycle_o, c0 + 32'd2); else pass_cnt++;
    if (data_o[31:0] !== 32'h10 || err_o[0] !== 1'b0) $display("FAIL latency_data: got err=%b data=%h, required err=0 data=00000010", err_o[0], data_o[31:0]); else pass_cnt++;
    idle(1);
    if (resp_v_o[0] !== 1'b0 || data_o[31:0] !== 32'h10) $display("FAIL hold_data: got v=%b data=%h, required v=0 data=00000010", resp_v_o[0], data_o[31:0]); else pass_cnt++;
    idle(3);
  endtask

  task automatic test_byte_write();
    drive(2'b10, 2'b10, 8'h30, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF);
    drive(2'b10, 2'b00, 8'h00, 32'h0, 32'h40, 32'h0, 32'h0);
    drive(2'b00, 2'b01, 8'h0F, 32'h44, 32'h0, 32'h12345678, 32'h0);
    drive(2'b01, 2'b00, 8'h00, 32'h44, 32'h0, 32'h0, 32'h0);
    idle(4);
    total_cnt++;
    if (model[16] !== 32'h0000BEEF) $display("FAIL byte_write_model: got %h, required 0000beef", model[16]); else pass_cnt++;
    total_cnt++;
    if (q0.size() + q1.size() != 0) $display("FAIL byte_write_drain: got %0d pending, required 0", q0.size() + q1.size()); else pass_cnt++;
  endtask

  task automatic test_multi_write();
    drive(2'b10, 2'b01, 8'h0F, 32'h80, 32'h80, 32'h11111111, 32'h0);
    drive(2'b00, 2'b11, 8'hFF, 32'h80, 32'h80, 32'h11111111, 32'h22222222);
    drive(2'b11, 2'b00, 8'h00, 32'h80, 32'h80, 32'h0, 32'h0);
    drive(2'b00, 2'b11, 8'h1F, 32'h88, 32'h88, 32'hAAAAAAAA, 32'h55555555);
    drive(2'b01, 2'b00, 8'h00, 32'h88, 32'h0, 32'h0, 32'h0);
    idle(4);
    total_cnt++;
    if (q0.size() + q1.size() != 0) $display("FAIL multi_write_drain: got %0d pending, required 0", q0.size() + q1.size()); else pass_cnt++;
  endtask

  task automatic test_addr_error();
    drive(2'b11, 2'b00, 8'h00, 32'h4000, 32'h3, 32'h0, 32'h0);
    drive(2'b00, 2'b11, 8'hFF, 32'h4000, 32'h5, 32'hCAFEF00D, 32'hCAFEF00D);
    drive(2'b11, 2'b00, 8'h00, 32'h0, 32'h4, 32'h0, 32'h0);
    drive(2'b01, 2'b00, 8'h00, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0);
    idle(4);
    total_cnt++;
    if (q0.size() + q1.size() != 0) $display("FAIL addr_error_drain: got %0d pending, required 0", q0.size() + q1.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int b0, b1, gaps;
    b0 = resp_cnt[0];
    b1 = resp_cnt[1];
    gaps = 0;
    for (int i = 0; i < 50; i++) begin
      drive(2'b11, 2'b00, 8'h00, 32'($urandom_range(0, 4095)) << 2, 32'($urandom_range(0, 4095)) << 2, 32'h0, 32'h0);
      if (i > 0 && resp_v_o !== 2'b11) gaps++;
    end
    idle(1);
    if (resp_v_o !== 2'b11) gaps++;
    idle(3);
    total_cnt += 4;
    if (resp_cnt[0] - b0 != 50) $display("FAIL b2b_count_ch0: got %0d, required 50", resp_cnt[0] - b0); else pass_cnt++;
    if (resp_cnt[1] - b1 != 50) $display("FAIL b2b_count_ch1: got %0d, required 50", resp_cnt[1] - b1); else pass_cnt++;
    if (gaps != 0) $display("FAIL b2b_gaps: got %0d, required 0", gaps); else pass_cnt++;
    if (q0.size() + q1.size() != 0) $display("FAIL b2b_drain: got %0d pending, required 0", q0.size() + q1.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int b0, b1, bad;
    drive(2'b00, 2'b01, 8'h0F, 32'h100, 32'h0, 32'hA5A5A5A5, 32'h0);
    for (int i = 0; i < 6; i++)
      drive(2'b11, 2'b00, 8'h00, 32'(i) << 2, 32'(i + 8) << 2, 32'h0, 32'h0);
    rst_i = 1'b1;
    #1;
    total_cnt++;
    if (ready_o !== 2'b00) $display("FAIL mid_reset_ready: got %b, required 00", ready_o); else pass_cnt++;
    @(negedge clk);
    #1;
    q0.delete();
    q1.delete();
    b0 = resp_cnt[0];
    b1 = resp_cnt[1];
    bad = 0;
    @(posedge clk);
    #2;
    repeat (3) begin
      if (resp_v_o !== 2'b00 || ready_o !== 2'b00) bad++;
      @(posedge clk);
      #2;
    end
    rst_i = 1'b0;
    idle(6);
    total_cnt += 2;
    if (bad != 0) $display("FAIL mid_reset_outputs: got %0d bad cycles, required 0", bad); else pass_cnt++;
    if (resp_cnt[0] != b0 || resp_cnt[1] != b1) $display("FAIL mid_reset_dropped: got %0d/%0d extra responses, required 0/0", resp_cnt[0] - b0, resp_cnt[1] - b1); else pass_cnt++;
    drive(2'b01, 2'b00, 8'h00, 32'h100, 32'h0, 32'h0, 32'h0);
    idle(4);
    total_cnt++;
    if (q0.size() + q1.size() != 0) $display("FAIL mid_reset_drain: got %0d pending, required 0", q0.size() + q1.size()); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int k, lows, nt_highs;
    rst_i = 1'b1;
    idle(2);
    total_cnt += 2;
    if (cycle_o !== 32'h0 || timeout_o !== 1'b0) $display("FAIL timeout_reset: got cycle=%0d timeout=%b, required 0/0", cycle_o, timeout_o); else pass_cnt++;
    if (nt_timeout !== 1'b0) $display("FAIL nt_timeout_reset: got %b, required 0", nt_timeout); else pass_cnt++;
    rst_i = 1'b0;
    k = 0;
    while (timeout_o !== 1'b1 && k < 100) begin
      idle(1);
      k++;
    end
    total_cnt += 2;
    if (timeout_o !== 1'b1) $display("FAIL timeout_rise: got %b after %0d cycles, required 1", timeout_o, k); else pass_cnt++;
    if (cycle_o !== 32'd20) $display("FAIL timeout_cycle: got %0d, required 20", cycle_o); else pass_cnt++;
    lows = 0;
    nt_highs = 0;
    repeat (1000) begin
      idle(1);
      if (timeout_o !== 1'b1) lows++;
      if (nt_timeout !== 1'b0) nt_highs++;
    end
    total_cnt += 3;
    if (lows != 0) $display("FAIL timeout_sticky: got %0d low cycles, required 0", lows); else pass_cnt++;
    if (nt_highs != 0) $display("FAIL timeout_disabled: got %0d high cycles, required 0", nt_highs); else pass_cnt++;
    if (cycle_o !== 32'd1020) $display("FAIL cycle_count: got %0d, required 1020", cycle_o); else pass_cnt++;
    rst_i = 1'b1;
    idle(1);
    total_cnt++;
    if (cycle_o !== 32'h0 || timeout_o !== 1'b0) $display("FAIL timeout_clear: got cycle=%0d timeout=%b, required 0/0", cycle_o, timeout_o); else pass_cnt++;
    rst_i = 1'b0;
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = 32'(i) << 2;
    #2;
    test_reset();
    test_read_latency();
    test_byte_write();
    test_multi_write();
    test_addr_error();
    test_back_to_back();
    test_reset_mid_burst();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
